// File: rtl/victim_cache_ctrl.sv
// victim_cache_ctrl: 4-way fully associative victim cache (lookup, install, dirty writeback to L2).
// Define VC_STATS_EN to add read hit/miss counters stat_hits and stat_misses.
module victim_cache_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 256,
    parameter int OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  l1_read,
    input  logic                  l1_write,
    input  logic [ADDR_WIDTH-1:0] l1_address,
    input  logic [LINE_WIDTH-1:0] l1_wdata,
    input  logic                  l1_wdirty,
    output logic [LINE_WIDTH-1:0] l1_rdata,
    output logic                  l1_resp,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp,
    output logic                  lru_load,
    output logic [1:0]            lru_used_way,
    input  logic [1:0]            lru_way
`ifdef VC_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses
`endif
);
    localparam int TW = ADDR_WIDTH - OFFSET_BITS;
    typedef enum logic [1:0] {IDLE, RESP, WB, L2RD} state_t;
    state_t state;
    logic [TW-1:0] tag [4];
    logic [LINE_WIDTH-1:0] data [4];
    logic [3:0] valid, dirty;
    logic [TW-1:0] req_tag;
    logic [1:0] hit_way, vic, vway, arr_way;
    logic hit, wb_need, arr_we;
    logic unused_ok;
    assign req_tag = l1_address[ADDR_WIDTH-1:OFFSET_BITS];
    assign unused_ok = ^l1_address[OFFSET_BITS-1:0];
    always_comb begin
        hit = 1'b0;
        hit_way = 2'd0;
        for (int i = 0; i < 4; i++)
            if (valid[i] && tag[i] == req_tag) begin
                hit = 1'b1;
                hit_way = 2'(i);
            end
    end
    // Invalid ways are filled first so the unreset LRU state is never trusted on a cold cache
    always_comb begin
        vic = lru_way;
        for (int i = 3; i >= 0; i--)
            if (!valid[i]) vic = 2'(i);
    end
    assign wb_need = !hit && valid[vic] && dirty[vic];
    assign arr_way = state == WB ? vway : (hit ? hit_way : vic);
    assign arr_we  = (state == IDLE && l1_write && !wb_need) || (state == WB && l2_resp);
    always_ff @(posedge clk)
        if (arr_we) begin
            tag[arr_way]  <= req_tag;
            data[arr_way] <= l1_wdata;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= IDLE;
            valid        <= '0;
            dirty        <= '0;
            vway         <= '0;
            l1_rdata     <= '0;
            l1_resp      <= 1'b0;
            l2_read      <= 1'b0;
            l2_write     <= 1'b0;
            l2_address   <= '0;
            l2_wdata     <= '0;
            lru_load     <= 1'b0;
            lru_used_way <= '0;
        end else begin
            case (state)
                IDLE:
                    if (l1_write && wb_need) begin
                        l2_address <= {tag[vic], {OFFSET_BITS{1'b0}}};
                        l2_wdata   <= data[vic];
                        l2_write   <= 1'b1;
                        vway       <= vic;
                        state      <= WB;
                    end else if (l1_write) begin
                        valid[arr_way] <= 1'b1;
                        dirty[arr_way] <= hit ? (dirty[hit_way] | l1_wdirty) : l1_wdirty;
                        l1_resp        <= 1'b1;
                        lru_load       <= 1'b1;
                        lru_used_way   <= arr_way;
                        state          <= RESP;
                    end else if (l1_read && hit) begin
                        l1_rdata     <= data[hit_way];
                        l1_resp      <= 1'b1;
                        lru_load     <= 1'b1;
                        lru_used_way <= hit_way;
                        state        <= RESP;
                    end else if (l1_read) begin
                        l2_address <= {req_tag, {OFFSET_BITS{1'b0}}};
                        l2_read    <= 1'b1;
                        state      <= L2RD;
                    end
                WB:
                    if (l2_resp) begin
                        l2_write     <= 1'b0;
                        valid[vway]  <= 1'b1;
                        dirty[vway]  <= l1_wdirty;
                        l1_resp      <= 1'b1;
                        lru_load     <= 1'b1;
                        lru_used_way <= vway;
                        state        <= RESP;
                    end
                L2RD:
                    if (l2_resp) begin
                        l1_rdata <= l2_rdata;
                        l2_read  <= 1'b0;
                        l1_resp  <= 1'b1;
                        state    <= RESP;
                    end
                default: begin
                    l1_resp  <= 1'b0;
                    lru_load <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
`ifdef VC_STATS_EN
    logic op_read, op_hit;
    // The last IDLE cycle before leaving is the request cycle, so its snapshot describes the op in RESP
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            op_read     <= 1'b0;
            op_hit      <= 1'b0;
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (state == IDLE) begin
                op_read <= !l1_write;
                op_hit  <= hit;
            end
            if (state == RESP && op_read) begin
                stat_hits   <= stat_hits + 32'(op_hit);
                stat_misses <= stat_misses + 32'(!op_hit);
            end
        end
`endif
endmodule

// File: tb/tb_victim_cache_ctrl.sv
// tb_victim_cache_ctrl: randomized scoreboard bench for victim_cache_ctrl with a behavioural cache model and L2 responder.
module tb_victim_cache_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic l1_read = 1'b0, l1_write = 1'b0, l1_wdirty = 1'b0;
    logic [31:0] l1_address = '0;
    logic [255:0] l1_wdata = '0, l1_rdata, l2_wdata, l2_rdata;
    logic l1_resp, l2_read, l2_write, l2_resp, lru_load;
    logic [31:0] l2_address;
    logic [1:0] lru_used_way, lru_way = '0;

    victim_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n), .l1_read(l1_read), .l1_write(l1_write),
        .l1_address(l1_address), .l1_wdata(l1_wdata), .l1_wdirty(l1_wdirty),
        .l1_rdata(l1_rdata), .l1_resp(l1_resp), .l2_read(l2_read), .l2_write(l2_write),
        .l2_address(l2_address), .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .lru_load(lru_load), .lru_used_way(lru_used_way), .lru_way(lru_way)
    );

    always #5 clk = ~clk;

    typedef struct { bit rd; logic [255:0] rdata; bit load; logic [1:0] way; } l1_exp_t;
    typedef struct { bit wr; logic [31:0] a; logic [255:0] d; } l2_exp_t;
    l1_exp_t exp_l1[$];
    l2_exp_t exp_l2[$];
    int checks = 0, errors = 0;
    int l2_fix = -1;
    bit l2_hold = 1'b0;

    // Reference model: four line slots, contents tracked by line number
    bit m_valid[4], m_dirty[4];
    logic [26:0] m_line[4];
    logic [255:0] m_data[4];

    task automatic chk(input string n, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, got, want);
        end
    endtask

    function automatic logic [255:0] l2fn(input logic [31:0] a);
        return {8{a ^ 32'hDEAD_BEEF}};
    endfunction

    function automatic logic [255:0] rnd_line();
        logic [255:0] d = '0;
        for (int i = 0; i < 8; i++) d = {d[223:0], $urandom()};
        return d;
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
    endtask

    function automatic int find(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_line[i] == a[31:5]) return i;
        return -1;
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [255:0] d, input bit dty,
                             input logic [1:0] lru, output bit l2);
        int h = find(a), v = -1;
        l2 = 0;
        if (h >= 0) begin
            m_data[h] = d;
            m_dirty[h] = m_dirty[h] | dty;
            exp_l1.push_back('{rd: 0, rdata: '0, load: 1, way: 2'(h)});
        end else begin
            for (int i = 0; i < 4; i++)
                if (v < 0 && !m_valid[i]) v = i;
            if (v < 0) v = int'(lru);
            if (m_valid[v] && m_dirty[v]) begin
                exp_l2.push_back('{wr: 1, a: {m_line[v], 5'b0}, d: m_data[v]});
                l2 = 1;
            end
            m_valid[v] = 1;
            m_dirty[v] = dty;
            m_line[v] = a[31:5];
            m_data[v] = d;
            exp_l1.push_back('{rd: 0, rdata: '0, load: 1, way: 2'(v)});
        end
    endtask

    task automatic mdl_read(input logic [31:0] a, output bit l2);
        int h = find(a);
        l2 = h < 0;
        if (h >= 0) exp_l1.push_back('{rd: 1, rdata: m_data[h], load: 1, way: 2'(h)});
        else begin
            exp_l2.push_back('{wr: 0, a: {a[31:5], 5'b0}, d: '0});
            exp_l1.push_back('{rd: 1, rdata: l2fn({a[31:5], 5'b0}), load: 0, way: '0});
        end
    endtask

    task automatic wait_resp(input string n, input int lat);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!l1_resp && cyc < 100);
        if (!l1_resp) chk({n, "_timeout"}, l1_resp, 1);
        else if (lat > 0) chk(n, cyc, lat);
    endtask

    task automatic op(input bit w, input bit r, input logic [31:0] a, input bit dty, input logic [1:0] lru);
        logic [255:0] d = rnd_line();
        bit l2a = 0, l2b = 0;
        @(negedge clk);
        if (w) mdl_write(a, d, dty, lru, l2a);
        if (r) mdl_read(a, l2b);
        lru_way = lru;
        l1_address = a;
        l1_wdata = d;
        l1_wdirty = dty;
        l1_write = w;
        l1_read = r;
        if (w) begin
            wait_resp("wr_latency", l2a ? 0 : 1);
            l1_write = 0;
        end
        if (r) begin
            wait_resp("rd_latency", l2b ? 0 : (w ? 2 : 1));
            l1_read = 0;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_l1_resp", l1_resp, 0);
        chk("rst_l2_read", l2_read, 0);
        chk("rst_l2_write", l2_write, 0);
        chk("rst_lru_load", lru_load, 0);
        chk("rst_l1_rdata", l1_rdata, 0);
        chk("rst_l2_address", l2_address, 0);
        chk("rst_l2_wdata", l2_wdata, 0);
        chk("rst_lru_used_way", lru_used_way, 0);
    endtask

    task automatic rst_seq();
        @(negedge clk);
        rst_n = 0;
        l1_read = 0;
        l1_write = 0;
        mdl_clear();
        exp_l1.delete();
        exp_l2.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Monitor: every l1_resp pops one expectation
    initial begin
        l1_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && l1_resp) begin
                if (exp_l1.size() == 0) chk("resp_unexpected", l1_resp, 0);
                else begin
                    e = exp_l1.pop_front();
                    if (e.rd) chk("l1_rdata", l1_rdata, e.rdata);
                    chk("lru_load", lru_load, e.load);
                    if (e.load) chk("lru_used_way", lru_used_way, e.way);
                end
            end else if (rst_n) chk("lru_load_idle", lru_load, 0);
        end
    end

    // L2 responder with random latency; also pulses l2_resp spuriously while no request is open
    initial begin
        l2_exp_t x;
        logic [31:0] a0;
        int d;
        l2_resp = 0;
        l2_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (l2_read || l2_write) && !l2_hold) begin
                if (exp_l2.size() == 0) chk("l2_unexpected", l2_read | l2_write, 0);
                else begin
                    x = exp_l2.pop_front();
                    chk("l2_write", l2_write, x.wr);
                    chk("l2_read", l2_read, !x.wr);
                    chk("l2_address", l2_address, x.a);
                    if (x.wr) chk("l2_wdata", l2_wdata, x.d);
                end
                d = l2_fix >= 0 ? l2_fix : int'($urandom_range(0, 3));
                a0 = l2_address;
                for (int k = 0; k < d; k++) begin
                    @(negedge clk);
                    chk("l2_req_held", {l2_read | l2_write, l2_address}, {1'b1, a0});
                end
                l2_rdata = l2fn(l2_address);
                l2_resp = 1;
                @(negedge clk);
                chk("l1_resp_after_l2", l1_resp, 1);
                chk("l2_req_dropped", l2_read | l2_write, 0);
                l2_resp = 0;
            end else if (!(l2_read || l2_write) && $urandom_range(0, 7) == 0) begin
                l2_rdata = rnd_line();
                l2_resp = 1;
                @(negedge clk);
                l2_resp = 0;
            end
        end
    end

    initial begin
        logic [31:0] a;
        int k;
        mdl_clear();
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1;
        for (int i = 1; i <= 4; i++) op(1, 0, 32'(i) << 8, 0, 2'($urandom_range(0, 3)));
        op(0, 1, 32'h200, 0, 2'd0);
        l2_fix = 2;
        op(0, 1, 32'h900, 0, 2'd0);
        l2_fix = -1;
        op(1, 0, 32'h300, 1, 2'd0);
        op(1, 0, 32'h500, 0, 2'd2);
        op(0, 1, 32'h51C, 0, 2'd0);
        op(1, 1, 32'h600, 1, 2'd3);
        for (int n = 0; n < 300; n++) begin
            a = (32'($urandom_range(1, 7)) << 8) | 32'($urandom_range(0, 31));
            k = $urandom_range(0, 9);
            op(k < 5 || k == 9, k >= 5, a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        rst_seq();
        for (int i = 10; i <= 13; i++) op(1, 0, 32'(i) << 8, 1, 2'($urandom_range(0, 3)));
        l2_hold = 1;
        @(negedge clk);
        lru_way = 2'd1;
        l1_address = 32'hE00;
        l1_wdata = rnd_line();
        l1_wdirty = 0;
        l1_write = 1;
        repeat (2) @(negedge clk);
        chk("wb_l2_write", l2_write, 1);
        chk("wb_l2_address", l2_address, 32'hB00);
        chk("wb_l2_wdata", l2_wdata, m_data[1]);
        rst_n = 0;
        #1;
        chk("rst_mid_wb_l2_write", l2_write, 0);
        chk_reset_outputs();
        l1_write = 0;
        mdl_clear();
        repeat (2) @(negedge clk);
        rst_n = 1;
        l2_hold = 0;
        op(0, 1, 32'hA00, 0, 2'd0);
        op(0, 1, 32'h300, 0, 2'd0);
        repeat (4) @(negedge clk);
        chk("pending_l1", exp_l1.size(), 0);
        chk("pending_l2", exp_l2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
